// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: substate encoding, ordered-set codes, timer loads and lane masking.
// Used by both the TX and RX link-training controllers.
package ltssm_pkg;

  localparam logic [3:0] detectQuiet          = 4'd0;
  localparam logic [3:0] detectActive         = 4'd1;
  localparam logic [3:0] pollingActive        = 4'd2;
  localparam logic [3:0] pollingConfiguration = 4'd3;
  localparam logic [3:0] configLinkWidthStart = 4'd4;
  localparam logic [3:0] configLinkWidthAccept = 4'd5;
  localparam logic [3:0] configLaneNumWait    = 4'd6;
  localparam logic [3:0] configLaneNumAccept  = 4'd7;
  localparam logic [3:0] configurationComplete = 4'd8;
  localparam logic [3:0] configurationIdle    = 4'd9;

  localparam logic [1:0] osNone = 2'd0;
  localparam logic [1:0] osTs1  = 2'd1;
  localparam logic [1:0] osTs2  = 2'd2;
  localparam logic [1:0] osIdle = 2'd3;

  localparam logic [5:0] timer2ms  = 6'd2;
  localparam logic [5:0] timer12ms = 6'd12;
  localparam logic [5:0] timer24ms = 6'd24;
  localparam logic [5:0] timer48ms = 6'd48;

  typedef struct packed {
    logic [1:0] os;
    logic       timerEn;
    logic [5:0] timer;
  } osCfg_t;

  // Bit mask of active lanes; zero for a lane count that is not a legal link width.
  function automatic logic [31:0] laneMask(input logic [4:0] lanes);
    logic [31:0] mask;
    case (lanes)
      5'd1:    mask = 32'h0000_0001;
      5'd2:    mask = 32'h0000_0003;
      5'd4:    mask = 32'h0000_000F;
      5'd8:    mask = 32'h0000_00FF;
      5'd16:   mask = 32'h0000_FFFF;
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/tx_os_counter.sv
// Saturating counters of ordered sets sent before (sentCount) and after (postCount) RX completion.
module tx_os_counter #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             incSent,
  input  logic             incPost,
  output logic [WIDTH-1:0] sentCount,
  output logic [WIDTH-1:0] postCount
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sentCount <= '0;
      postCount <= '0;
    end else if (clear) begin
      sentCount <= '0;
      postCount <= '0;
    end else begin
      if (incSent && (sentCount != {WIDTH{1'b1}})) sentCount <= sentCount + 1'b1;
      if (incPost && (postCount != {WIDTH{1'b1}})) postCount <= postCount + 1'b1;
    end
  end

endmodule

// File: rtl/master_tx_ltssm.sv
// TX-side LTSSM substate controller: picks the ordered set to send, drives electrical idle,
// enforces minimum OS counts around RX completion and reports finish/exitTo.
module master_tx_ltssm
  import ltssm_pkg::*;
#(
  parameter int unsigned MAXLANES      = 16,
  parameter int unsigned POLL_MIN_TS1  = 1024,
  parameter int unsigned POST_RX_COUNT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          substate,
  input  logic [4:0]          numberOfDetectedLanes,
  input  logic                osSent,
  input  logic                rxFinish,
  input  logic                rxFailed,
  input  logic                timeOut,
  output logic [1:0]          osType,
  output logic [MAXLANES-1:0] txElecIdle,
  output logic                enableScrambler,
  output logic                finish,
  output logic [3:0]          exitTo,
  output logic [5:0]          setTimer,
  output logic                enableTimer,
  output logic                resetTimer
);

  localparam int unsigned CntW = 11;

  localparam logic [1:0] START = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] POST  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]      state, stateNext;
  logic [3:0]      lastState, lastStateNext;
  logic            rxDone, rxDoneNext;
  logic [CntW-1:0] minSent, postTarget;
  osCfg_t          cfg;

  logic            clearCnt, loadCfg, success, failed;
  logic [CntW-1:0] sentCount, postCount;

  // Table decode for the requested substate.
  osCfg_t          newCfg;
  logic [CntW-1:0] newMin, newPost;
  logic            legal;

  always_comb begin
    newCfg  = '{os: osNone, timerEn: 1'b1, timer: timer24ms};
    newMin  = '0;
    newPost = '0;
    legal   = 1'b1;
    case (substate)
      detectQuiet:  newCfg = '{os: osNone, timerEn: 1'b1, timer: timer12ms};
      detectActive: newCfg = '{os: osNone, timerEn: 1'b0, timer: 6'd0};
      pollingActive: begin
        newCfg = '{os: osTs1, timerEn: 1'b1, timer: timer24ms};
        newMin = CntW'(POLL_MIN_TS1);
      end
      pollingConfiguration: begin
        newCfg  = '{os: osTs2, timerEn: 1'b1, timer: timer48ms};
        newPost = CntW'(POST_RX_COUNT);
      end
      configLinkWidthStart, configLinkWidthAccept, configLaneNumAccept:
        newCfg = '{os: osTs1, timerEn: 1'b1, timer: timer24ms};
      configLaneNumWait: newCfg = '{os: osTs1, timerEn: 1'b1, timer: timer2ms};
      configurationComplete: begin
        newCfg  = '{os: osTs2, timerEn: 1'b1, timer: timer24ms};
        newPost = CntW'(POST_RX_COUNT);
      end
      configurationIdle: begin
        newCfg  = '{os: osIdle, timerEn: 1'b1, timer: timer24ms};
        newPost = CntW'(POST_RX_COUNT);
      end
      default: legal = 1'b0;
    endcase
  end

  // Counts including this cycle's osSent, so a completing pulse is not lost.
  logic [CntW:0] sentEff, postEff;
  logic          changed, minReached, postReached, failHit;

  assign sentEff     = {1'b0, sentCount} + {{CntW{1'b0}}, osSent};
  assign postEff     = {1'b0, postCount} + {{CntW{1'b0}}, osSent};
  assign minReached  = sentEff >= {1'b0, minSent};
  assign postReached = postEff >= {1'b0, postTarget};
  assign changed     = substate != lastState;
  assign failHit     = timeOut | rxFailed;

  always_comb begin
    stateNext     = state;
    lastStateNext = lastState;
    rxDoneNext    = rxDone;
    clearCnt      = 1'b0;
    loadCfg       = 1'b0;
    success       = 1'b0;
    failed        = 1'b0;
    case (state)
      START: begin
        if (changed) begin
          lastStateNext = substate;
          clearCnt      = 1'b1;
          rxDoneNext    = 1'b0;
          if (legal) begin
            loadCfg   = 1'b1;
            stateNext = COUNT;
          end
        end
      end
      COUNT: begin
        if (changed) begin
          stateNext = START;
        end else begin
          if (rxFinish) rxDoneNext = 1'b1;
          if ((rxDone || rxFinish) && minReached) begin
            if (postTarget == '0) begin
              stateNext = DONE;
              success   = 1'b1;
            end else begin
              stateNext = POST;
            end
          end else if (failHit) begin
            stateNext = DONE;
            failed    = 1'b1;
          end
        end
      end
      POST: begin
        if (changed) begin
          stateNext = START;
        end else if (postReached) begin
          stateNext = DONE;
          success   = 1'b1;
        end else if (failHit) begin
          stateNext = DONE;
          failed    = 1'b1;
        end
      end
      default: stateNext = START;
    endcase
  end

  tx_os_counter #(
    .WIDTH(CntW)
  ) uCounter (
    .clk      (clk),
    .reset    (reset),
    .clear    (clearCnt),
    .incSent  ((state == COUNT) && osSent && !changed),
    .incPost  ((state == POST) && osSent && !changed),
    .sentCount(sentCount),
    .postCount(postCount)
  );

  // Registered outputs follow the next state so they line up with it.
  logic                active;
  osCfg_t              cfgNext;
  logic [MAXLANES-1:0] laneIdle, elecIdleNext;
  logic [31:0]         mask;

  assign active  = (stateNext == COUNT) || (stateNext == POST);
  assign cfgNext = loadCfg ? newCfg : cfg;
  assign mask    = laneMask(numberOfDetectedLanes);

  always_comb begin
    if (32'(numberOfDetectedLanes) > MAXLANES) laneIdle = '1;
    else                                       laneIdle = ~mask[MAXLANES-1:0];
    if ((lastStateNext <= detectActive) || (lastStateNext > configurationIdle))
      elecIdleNext = '1;
    else
      elecIdleNext = laneIdle;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= START;
      lastState       <= 4'hF;
      rxDone          <= 1'b0;
      cfg             <= '0;
      minSent         <= '0;
      postTarget      <= '0;
      osType          <= osNone;
      txElecIdle      <= '1;
      enableScrambler <= 1'b0;
      finish          <= 1'b0;
      exitTo          <= 4'd0;
      setTimer        <= 6'd0;
      enableTimer     <= 1'b0;
      resetTimer      <= 1'b0;
    end else begin
      state     <= stateNext;
      lastState <= lastStateNext;
      rxDone    <= rxDoneNext;
      if (loadCfg) begin
        cfg        <= newCfg;
        minSent    <= newMin;
        postTarget <= newPost;
      end
      osType          <= active ? cfgNext.os : osNone;
      txElecIdle      <= elecIdleNext;
      enableScrambler <= active && (lastStateNext == configurationIdle);
      finish          <= success | failed;
      exitTo          <= success ? lastState + 4'd1 : 4'd0;
      setTimer        <= (active && cfgNext.timerEn) ? cfgNext.timer : 6'd0;
      enableTimer     <= active && cfgNext.timerEn;
      resetTimer      <= loadCfg && newCfg.timerEn;
    end
  end

endmodule

// File: doc/master_tx_ltssm.md
Name: master_tx_ltssm

Overview:
Transmit-side counterpart of the master RX LTSSM controller in the PCIe Gen5 link-training path. For each substate requested by the main LTSSM it:
- selects the ordered set (OS) the lane OS generators transmit (none, TS1, TS2, IDLE);
- controls per-lane electrical idle;
- counts transmitted OSs and enforces the spec minimum counts before and after the RX side reports completion;
- reports finish/exitTo to the main LTSSM.
It shares the substate encoding and the external timer with the RX controller.

Parameters:
MAXLANES, 16, number of physical lanes; width of the per-lane electrical-idle bus.
POLL_MIN_TS1, 1024, minimum number of TS1 sent in pollingActive before exit.
POST_RX_COUNT, 16, number of OSs sent after rxFinish in substates that require post-RX transmission.

Ports:
clk  input  1  clock.
reset  input  1  reset, asynchronous, active-low.
substate  input  4  requested LTSSM substate (shared encoding).
numberOfDetectedLanes  input  5  active lane count (1, 2, 4, 8, 16).
osSent  input  1  one-cycle pulse; one complete OS was transmitted on all active lanes.
rxFinish  input  1  one-cycle pulse from the RX controller; RX success for the current substate.
rxFailed  input  1  one-cycle pulse from the RX controller; RX failure (exit to detect).
timeOut  input  1  external timer expired.
osType  output  2  0 none, 1 TS1, 2 TS2, 3 IDLE.
txElecIdle  output  MAXLANES  per-lane electrical idle; 1 = idle.
enableScrambler  output  1  high only in configurationIdle.
finish  output  1  one-cycle completion pulse.
exitTo  output  4  next substate; valid while finish = 1.
setTimer  output  6  timer load value.
enableTimer  output  1  timer run enable.
resetTimer  output  1  timer reload; high during the first COUNT cycle only.

Behaviour:
- All outputs are registered. Reset values:
  - osType = 0, txElecIdle = all 1s, enableScrambler = 0, finish = 0, exitTo = 0.
  - setTimer = 0, enableTimer = 0, resetTimer = 0.
  - Internal state: lastState = 4'hF, sentCount = 0, postCount = 0, rxDone = 0.
- State machine: START, COUNT, POST, DONE.
- START:
  - When substate != lastState: latch lastState <= substate, clear all counters and rxDone, load the per-substate table, go to COUNT next cycle.
  - Otherwise stay in START with osType = 0 and timer outputs 0.
- Per-substate table (osType / minimum sent / post-RX count / setTimer):
  - detectQuiet (0): none / 0 / 0 / 12.
  - detectActive (1): none / 0 / 0 / 0; timer disabled.
  - pollingActive (2): TS1 / POLL_MIN_TS1 / 0 / 24.
  - pollingConfiguration (3): TS2 / 0 / POST_RX_COUNT / 48.
  - configuration substates 4–7: TS1 / 0 / 0 / 24; substate 6 uses timer 2.
  - configurationComplete (8): TS2 / 0 / POST_RX_COUNT / 24.
  - configurationIdle (9): IDLE / 0 / POST_RX_COUNT / 24.
  - Codes 10–15: stay in START, no outputs.
- txElecIdle:
  - All 1s in substates 0–1.
  - Otherwise the low numberOfDetectedLanes bits are 0 and the rest are 1. An illegal lane count gives all 1s.
- COUNT:
  - sentCount increments on osSent, saturating at 2047.
  - rxDone sets on rxFinish and stays set.
  - Exit to POST when rxDone (or rxFinish this cycle) AND sentCount (including this cycle's osSent) >= minimum. If post count = 0, go directly to DONE-success.
- POST: postCount increments on osSent. Reaching the post count goes to DONE-success. The timer keeps running.
- Failure: timeOut or rxFailed in COUNT/POST goes to DONE-failure. If the success condition completes in the same cycle, success wins.
- DONE:
  - finish = 1 for exactly one cycle; osType = 0.
  - exitTo = substate + 1 on success; exitTo = 0 (detectQuiet) on failure.
  - Next state is START. lastState is not cleared, so an unchanged substate does not retrigger.
- Substate change while in COUNT/POST: abort with no finish, go to START. The new request is accepted on the following cycle.
- Asynchronous reset mid-operation: immediate return to the reset values.

Decomposition:
- Shared package ltssm_pkg:
  - substate localparams (0–9);
  - osType codes;
  - timer constants;
  - a lane-mask function (lane count to bit mask), also used by the RX controller.
- One sub-module: tx_os_counter. Holds the saturating sentCount and postCount with clear and increment.

Test Plan:
- Reset, then substate = 2. In COUNT: osType = 1, setTimer = 24, resetTimer high for one cycle. Send 1023 osSent plus rxFinish -> no finish. Send 1 more osSent -> finish with exitTo = 3.
- substate = 3, lanes = 4: txElecIdle = 16'hFFF0. rxFinish after 5 OSs, then 15 osSent -> no finish; 16th osSent -> finish with exitTo = 4.
- substate = 8, timeOut after 3 post OSs -> finish with exitTo = 0. Same substate held afterwards -> stays in START, no further finish.
- substate = 9: enableScrambler = 1 and osType = 3. In the same cycle, the 16th post osSent and timeOut both occur -> success, exitTo = 10.
- substate changes 4 -> 5 while in COUNT: no finish for 4, START for 1 cycle, then COUNT for 5 with osType = 1.
- substate = 0: txElecIdle all 1s, rxFinish -> finish with exitTo = 1. Reset asserted mid-COUNT -> all outputs return to reset values asynchronously.
